// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the MIPS control-path pipeline: bundle bit positions,
// forwarding select codes and the architectural register numbers used by traps.
package pipe_ctrl_pkg;

    // WB bundle {MemtoReg[1:0], RegWrite}
    localparam int WB_REGWRITE    = 0;
    localparam int WB_MEMTOREG_LO = 1;

    // MEM bundle {MemRead, MemWrite}
    localparam int MEM_MEMWRITE   = 0;
    localparam int MEM_MEMREAD    = 1;

    // EX bundle {ExtOp, PCSrc[2:0], LUOp, Sign, ALUFun[5:0], RegDst[1:0], ALUSrc2, ALUSrc1}
    localparam int EX_ALUSRC1     = 0;
    localparam int EX_ALUSRC2     = 1;
    localparam int EX_REGDST_LO   = 2;
    localparam int EX_ALUFUN_LO   = 4;
    localparam int EX_SIGN        = 10;
    localparam int EX_LUOP        = 11;
    localparam int EX_PCSRC_LO    = 12;
    localparam int EX_EXTOP       = 15;

    localparam logic [1:0] REGDST_XP   = 2'b11;
    localparam logic [1:0] MEMTOREG_PC = 2'b10;

    localparam int XP = 26;
    localparam int RA = 31;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/pipe_hazard_ctrl_stage_reg.sv
// One pipeline control register: async clear, enable, and synchronous flush to a bubble.
module pipe_stage_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         flush,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            q <= '0;
        else if (en)
            q <= flush ? {W{1'b0}} : d;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Control-path pipeline for the 5-stage MIPS core: carries WB|MEM|EX bundles and
// destinations, resolves forwarding, load-use stalls, flushes and trap injection.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int EX_W  = 16,
    parameter int MEM_W = 2,
    parameter int WB_W  = 3,
    parameter int RA_W  = 5,
    parameter int PC_W  = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        id_valid,
    input  logic [WB_W+MEM_W+EX_W-1:0]  id_ctrl,
    input  logic [RA_W-1:0]             id_rs,
    input  logic [RA_W-1:0]             id_rt,
    input  logic                        id_use_rs,
    input  logic                        id_use_rt,
    input  logic [RA_W-1:0]             id_dst,
    input  logic [PC_W-1:0]             id_pc,
    input  logic                        id_jump,
    input  logic                        id_exc,
    input  logic                        ex_br_taken,
    input  logic                        irq,
    output logic                        stall,
    output logic                        flush_ifid,
    output logic                        irq_take,
    output logic                        exc_take,
    output logic [PC_W-1:0]             epc,
    output logic [EX_W-1:0]             ex_ctrl,
    output logic [MEM_W-1:0]            mem_ctrl,
    output logic [WB_W-1:0]             wb_ctrl,
    output logic [RA_W-1:0]             ex_dst,
    output logic [RA_W-1:0]             mem_dst,
    output logic [RA_W-1:0]             wb_dst,
    output logic [1:0]                  fwd_a,
    output logic [1:0]                  fwd_b
);

    localparam int CTRL_W  = WB_W + MEM_W + EX_W;
    localparam int IDEX_W  = CTRL_W + 3 * RA_W;
    localparam int EXMEM_W = WB_W + MEM_W + RA_W;
    localparam int MEMWB_W = WB_W + RA_W;
    localparam logic [RA_W-1:0] XP_ADDR = RA_W'(XP);

    logic [IDEX_W-1:0]  idex_d, idex_q;
    logic [EXMEM_W-1:0] exmem_q;
    logic [MEMWB_W-1:0] memwb_q;

    logic [CTRL_W-1:0]  idex_ctrl;
    logic [RA_W-1:0]    ex_rs, ex_rt;
    logic [MEM_W-1:0]   ex_mem_bits;
    logic [WB_W-1:0]    ex_wb_bits, mem_wb_bits;

    assign {idex_ctrl, ex_dst, ex_rs, ex_rt} = idex_q;
    assign ex_ctrl     = idex_ctrl[EX_W-1:0];
    assign ex_mem_bits = idex_ctrl[EX_W +: MEM_W];
    assign ex_wb_bits  = idex_ctrl[EX_W+MEM_W +: WB_W];
    assign {mem_wb_bits, mem_ctrl, mem_dst} = exmem_q;
    assign {wb_ctrl, wb_dst} = memwb_q;

    // ---------------- hazard resolution ----------------
    logic br, exc_i, load_use, stall_i, irq_i, flush_i;

    always_comb begin
        br       = ex_br_taken;
        exc_i    = id_valid & id_exc & ~br;
        load_use = ex_mem_bits[MEM_MEMREAD] & (ex_dst != '0) &
                   ((id_use_rs & (id_rs == ex_dst)) | (id_use_rt & (id_rt == ex_dst)));
        stall_i  = load_use & ~br & ~exc_i;
        irq_i    = irq & id_valid & ~id_pc[PC_W-1] & ~br & ~stall_i & ~exc_i;
        // Any PC redirect kills the wrong-path fetch sitting in IF/ID, traps included.
        flush_i  = br | exc_i | irq_i | (id_jump & ~stall_i);
    end

    // Pulses are suppressed while reset is held so nothing redirects the PC.
    assign stall      = reset & stall_i;
    assign flush_ifid = reset & flush_i;
    assign irq_take   = reset & irq_i;
    assign exc_take   = reset & exc_i;

    // Trap bundle: write the restart PC into Xp.
    logic [CTRL_W-1:0] xp_ctrl;
    always_comb begin
        xp_ctrl = '0;
        xp_ctrl[EX_W+MEM_W+WB_REGWRITE]            = 1'b1;
        xp_ctrl[EX_W+MEM_W+WB_MEMTOREG_LO +: 2]    = MEMTOREG_PC;
        xp_ctrl[EX_REGDST_LO +: 2]                 = REGDST_XP;
    end

    always_comb begin
        idex_d = '0;
        if (exc_i | irq_i)
            idex_d = {xp_ctrl, XP_ADDR, {(2*RA_W){1'b0}}};
        else if (id_valid)
            idex_d = {id_ctrl, id_dst, id_rs, id_rt};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            epc <= '0;
        else if (exc_i)
            epc <= id_pc + PC_W'(4);
        else if (irq_i)
            epc <= id_pc;
    end

    // ---------------- stage registers ----------------
    pipe_stage_reg #(.W(IDEX_W)) u_idex (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .flush (br | stall_i),
        .d     (idex_d),
        .q     (idex_q)
    );

    pipe_stage_reg #(.W(EXMEM_W)) u_exmem (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .flush (1'b0),
        .d     ({ex_wb_bits, ex_mem_bits, ex_dst}),
        .q     (exmem_q)
    );

    pipe_stage_reg #(.W(MEMWB_W)) u_memwb (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .flush (1'b0),
        .d     ({mem_wb_bits, mem_dst}),
        .q     (memwb_q)
    );

    // ---------------- forwarding ----------------
    logic [1:0][RA_W-1:0] ex_src;
    logic [1:0][1:0]      fwd_sel;

    assign ex_src = {ex_rt, ex_rs};

    for (genvar op = 0; op < 2; op++) begin : g_fwd
        logic [1:0] sel;
        // EX/MEM holds the younger result, so it wins over MEM/WB.
        always_comb begin
            sel = FWD_RF;
            if (mem_wb_bits[WB_REGWRITE] && (mem_dst != '0) && (mem_dst == ex_src[op]))
                sel = FWD_MEM;
            else if (wb_ctrl[WB_REGWRITE] && (wb_dst != '0) && (wb_dst == ex_src[op]))
                sel = FWD_WB;
        end
        assign fwd_sel[op] = sel;
    end

    assign fwd_a = fwd_sel[0];
    assign fwd_b = fwd_sel[1];

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: stimulus predicts each cycle's outputs from an instruction-level
// pipeline model; a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;

    logic        clk, reset;
    logic        id_valid, id_use_rs, id_use_rt, id_jump, id_exc, ex_br_taken, irq;
    logic [20:0] id_ctrl;
    logic [4:0]  id_rs, id_rt, id_dst;
    logic [31:0] id_pc;
    logic        stall, flush_ifid, irq_take, exc_take;
    logic [31:0] epc;
    logic [15:0] ex_ctrl;
    logic [1:0]  mem_ctrl;
    logic [2:0]  wb_ctrl;
    logic [4:0]  ex_dst, mem_dst, wb_dst;
    logic [1:0]  fwd_a, fwd_b;

    pipe_hazard_ctrl dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_dst(id_dst), .id_pc(id_pc), .id_jump(id_jump), .id_exc(id_exc),
        .ex_br_taken(ex_br_taken), .irq(irq), .stall(stall), .flush_ifid(flush_ifid),
        .irq_take(irq_take), .exc_take(exc_take), .epc(epc), .ex_ctrl(ex_ctrl),
        .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl), .ex_dst(ex_dst), .mem_dst(mem_dst),
        .wb_dst(wb_dst), .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // An in-flight instruction as the model sees it.
    typedef struct {
        logic [2:0]  wb;
        logic [1:0]  mem;
        logic [15:0] ex;
        logic [4:0]  dst, rs, rt;
    } instr_t;

    typedef struct {
        logic        stall, flush, irqt, exct;
        logic [31:0] epc;
        logic [15:0] ex;
        logic [1:0]  mem;
        logic [2:0]  wb;
        logic [4:0]  exd, memd, wbd;
        logic [1:0]  fa, fb;
    } exp_t;

    instr_t pipe_m [3];   // 0 = EX, 1 = MEM, 2 = WB
    logic [31:0] epc_m;
    exp_t exp_q [$];
    int n_cmp = 0;
    int n_err = 0;

    localparam logic [20:0] ALU = {3'b001, 2'b00, 16'h0010};
    localparam logic [20:0] LW  = {3'b011, 2'b10, 16'h8003};
    localparam logic [20:0] BEQ = {3'b000, 2'b00, 16'h1000};

    function automatic instr_t bubble();
        instr_t b;
        b = '{wb: 3'b0, mem: 2'b0, ex: 16'h0, dst: 5'd0, rs: 5'd0, rt: 5'd0};
        return b;
    endfunction

    // Newest producer of a register wins; $0 never comes from the pipeline.
    function automatic logic [1:0] fwd_of(input logic [4:0] src);
        if (src == 5'd0) return 2'd0;
        if (pipe_m[1].wb[0] && pipe_m[1].dst == src) return 2'd1;
        if (pipe_m[2].wb[0] && pipe_m[2].dst == src) return 2'd2;
        return 2'd0;
    endfunction

    task automatic step(input logic rst, input logic v, input logic [20:0] ctrl,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [4:0] dst,
                        input logic [31:0] pc, input logic jmp, input logic exc,
                        input logic br, input logic irqi);
        exp_t   e;
        instr_t nw;
        logic   ex_c, lu, stl, irq_c;
        @(posedge clk); #1;
        reset = rst; id_valid = v; id_ctrl = ctrl; id_rs = rs; id_rt = rt;
        id_use_rs = urs; id_use_rt = urt; id_dst = dst; id_pc = pc;
        id_jump = jmp; id_exc = exc; ex_br_taken = br; irq = irqi;
        e = '{default: '0};
        if (!rst) begin
            for (int i = 0; i < 3; i++) pipe_m[i] = bubble();
            epc_m = 32'h0;
            exp_q.push_back(e);
            return;
        end
        ex_c  = v & exc & ~br;
        lu    = pipe_m[0].mem[1] && pipe_m[0].dst != 0 &&
                ((urs && rs == pipe_m[0].dst) || (urt && rt == pipe_m[0].dst));
        stl   = lu & ~br & ~ex_c;
        irq_c = irqi & v & ~pc[31] & ~br & ~stl & ~ex_c;
        e.stall = stl;
        e.flush = br | ex_c | irq_c | (jmp & ~stl);
        e.irqt  = irq_c;
        e.exct  = ex_c;
        e.epc   = epc_m;
        e.ex    = pipe_m[0].ex;   e.exd  = pipe_m[0].dst;
        e.mem   = pipe_m[1].mem;  e.memd = pipe_m[1].dst;
        e.wb    = pipe_m[2].wb;   e.wbd  = pipe_m[2].dst;
        e.fa    = fwd_of(pipe_m[0].rs);
        e.fb    = fwd_of(pipe_m[0].rt);
        exp_q.push_back(e);

        nw = bubble();
        if (ex_c || irq_c)
            nw = '{wb: 3'b101, mem: 2'b00, ex: 16'h000C, dst: 5'd26, rs: 5'd0, rt: 5'd0};
        else if (v && !br && !stl)
            nw = '{wb: ctrl[20:18], mem: ctrl[17:16], ex: ctrl[15:0], dst: dst, rs: rs, rt: rt};
        if (ex_c)       epc_m = pc + 32'd4;
        else if (irq_c) epc_m = pc;
        pipe_m[2] = pipe_m[1];
        pipe_m[1] = pipe_m[0];
        pipe_m[0] = nw;
    endtask

    task automatic rnd_step(input logic rst);
        logic [31:0] pc;
        pc = $urandom; pc[1:0] = 2'b00; pc[31] = ($urandom_range(0, 3) == 0);
        step(rst, $urandom_range(0, 7) != 0, 21'($urandom),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)), pc,
             $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
             $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0);
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++)
            step(1, 1, 21'h0, 0, 0, 0, 0, 0, 32'h1000, 0, 0, 0, 0);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, want, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("stall", 32'(stall), 32'(e.stall));
            chk("flush_ifid", 32'(flush_ifid), 32'(e.flush));
            chk("irq_take", 32'(irq_take), 32'(e.irqt));
            chk("exc_take", 32'(exc_take), 32'(e.exct));
            chk("epc", epc, e.epc);
            chk("ex_ctrl", 32'(ex_ctrl), 32'(e.ex));
            chk("mem_ctrl", 32'(mem_ctrl), 32'(e.mem));
            chk("wb_ctrl", 32'(wb_ctrl), 32'(e.wb));
            chk("ex_dst", 32'(ex_dst), 32'(e.exd));
            chk("mem_dst", 32'(mem_dst), 32'(e.memd));
            chk("wb_dst", 32'(wb_dst), 32'(e.wbd));
            chk("fwd_a", 32'(fwd_a), 32'(e.fa));
            chk("fwd_b", 32'(fwd_b), 32'(e.fb));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1);
    end

    initial begin
        reset = 1'b0; id_valid = 0; id_ctrl = '0; id_rs = '0; id_rt = '0;
        id_use_rs = 0; id_use_rt = 0; id_dst = '0; id_pc = '0;
        id_jump = 0; id_exc = 0; ex_br_taken = 0; irq = 0;
        for (int i = 0; i < 3; i++) pipe_m[i] = bubble();
        epc_m = '0;

        // reset with noisy inputs: no pulses allowed
        step(0, 1, ALU, 1, 1, 1, 1, 1, 32'h40, 1, 1, 1, 1);
        step(0, 1, LW, 2, 1, 1, 0, 1, 32'h44, 0, 0, 1, 1);
        // add $1,$2,$3 ; add $4,$1,$5  -> EX/MEM forward
        step(1, 1, ALU, 2, 3, 1, 1, 1, 32'h1000, 0, 0, 0, 0);
        step(1, 1, ALU, 1, 5, 1, 1, 4, 32'h1004, 0, 0, 0, 0);
        nop(3);
        // one NOP between -> MEM/WB forward
        step(1, 1, ALU, 2, 3, 1, 1, 1, 32'h1010, 0, 0, 0, 0);
        nop(1);
        step(1, 1, ALU, 1, 5, 1, 1, 4, 32'h1018, 0, 0, 0, 0);
        nop(3);
        // lw $1,0($2) ; add $4,$1,$1  -> one stall then MEM/WB forward on both
        step(1, 1, LW, 2, 1, 1, 0, 1, 32'h1020, 0, 0, 0, 0);
        step(1, 1, ALU, 1, 1, 1, 1, 4, 32'h1024, 0, 0, 0, 0);
        step(1, 1, ALU, 1, 1, 1, 1, 4, 32'h1024, 0, 0, 0, 0);
        nop(3);
        // load into $0 never stalls or forwards
        step(1, 1, LW, 2, 0, 1, 0, 0, 32'h1030, 0, 0, 0, 0);
        step(1, 1, ALU, 0, 0, 1, 1, 4, 32'h1034, 0, 0, 0, 0);
        nop(3);
        // taken branch overrides a pending load-use stall
        step(1, 1, LW, 2, 1, 1, 0, 1, 32'h1040, 0, 0, 0, 0);
        step(1, 1, ALU, 1, 1, 1, 1, 4, 32'h1044, 0, 0, 1, 0);
        nop(3);
        // jump: flush IF/ID, jump continues
        step(1, 1, BEQ, 1, 2, 1, 1, 0, 32'h1050, 1, 0, 0, 0);
        nop(2);
        // irq in user mode, then masked in kernel mode
        step(1, 1, ALU, 2, 3, 1, 1, 1, 32'h00000040, 0, 0, 0, 1);
        nop(1);
        step(1, 1, ALU, 2, 3, 1, 1, 1, 32'h80000040, 0, 0, 0, 1);
        nop(1);
        // undefined opcode -> exc_take, epc = pc+4, Xp write reaches WB 3 cycles on
        step(1, 1, 21'h1F_FFFF, 2, 3, 1, 1, 7, 32'h00000100, 0, 1, 0, 0);
        nop(4);

        for (int i = 0; i < 400; i++) rnd_step((i % 150) < 147);

        nop(3);
        @(posedge clk);
        @(negedge clk); #1;
        chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
